// File: rtl/sensor_cmd_router_pkg.sv
// Shared types and constants for the sensor command router and its byte serializer.
package sensor_router_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    ERR   = 3'd4,
    TERM  = 3'd5
  } router_state_e;

  localparam logic [7:0] ERR_BYTE      = 8'h45;
  localparam logic [7:0] DEF_TERM_BYTE = 8'h0D;

  // Bytes needed to carry a w-bit sensor result.
  function automatic int nbytes(int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/sensor_cmd_router_if.sv
// UART-side byte streams of the sensor command router.
// rx: rx_valid is a 1-cycle strobe, no backpressure. tx: a byte transfers on a clock edge
// where tx_valid && tx_ready; once raised, tx_valid and tx_data hold until that edge.
interface sensor_cmd_router_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );
endinterface

// File: rtl/sensor_cmd_router_byte_serializer.sv
// Loads a DATA_W word and emits it LSB-first as bytes over valid/ready; done marks
// the cycle whose clock edge transfers the last byte.
module byte_serializer
  import sensor_router_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        dout,
  output logic              valid,
  input  logic              ready,
  output logic              done
);
  localparam int NBYTES = nbytes(DATA_W);
  localparam int SH_W   = NBYTES * 8;
  localparam int CNT_W  = $clog2(NBYTES + 1);

  logic [SH_W-1:0]  sh;
  logic [CNT_W-1:0] cnt;
  logic             last;

  assign dout = sh[7:0];
  assign last = (cnt == CNT_W'(NBYTES - 1));
  assign done = valid && ready && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // Widening cast zero-pads the top byte when DATA_W is not a multiple of 8.
      sh    <= SH_W'(din);
      cnt   <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (last) begin
        valid <= 1'b0;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        sh  <= sh >> 8;
      end
    end
  end
endmodule

// File: rtl/sensor_cmd_router.sv
// Decodes an ASCII command byte, starts the matching sensor, waits for its result with a
// timeout and streams the result (or 'E') plus a terminator back over the tx byte stream.
module sensor_cmd_router
  import sensor_router_pkg::*;
#(
  parameter int               N_CH        = 2,
  parameter int               DATA_W      = 16,
  parameter logic [N_CH*8-1:0] CMD_CODES  = {8'h44, 8'h54},
  parameter int               TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0]       TERM_BYTE   = DEF_TERM_BYTE
) (
  input  logic                     clk,
  input  logic                     rst,
  sensor_cmd_router_if.master      uart,
  output logic [N_CH-1:0]          sns_start,
  input  logic [N_CH*DATA_W-1:0]   sns_data,
  input  logic [N_CH-1:0]          sns_valid,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     rx_drop,
  output router_state_e            dbg_state
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  router_state_e     state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   hit_ch;
  logic              hit;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic              ser_load;
  logic              ser_ready;
  logic              ser_done;
  logic              ser_valid;
  logic [7:0]        ser_data;

  // Scan from the top so the lowest matching channel index is the one kept.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (uart.rx_data == CMD_CODES[8*i +: 8]) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  always_comb begin
    sel_data  = sns_data[DATA_W*ch +: DATA_W];
    sel_valid = sns_valid[ch];
  end

  assign ser_load  = (state == WAIT) && sel_valid;
  assign ser_ready = (state == SEND) && uart.tx_ready;

  // Result bytes come from the serializer; 'E' and the terminator from local registers.
  assign uart.tx_data  = (state == SEND) ? ser_data  : tx_data_q;
  assign uart.tx_valid = (state == SEND) ? ser_valid : tx_valid_q;
  assign busy          = (state != IDLE);
  assign dbg_state     = state;

  byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .din   (sel_data),
    .dout  (ser_data),
    .valid (ser_valid),
    .ready (ser_ready),
    .done  (ser_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ch          <= '0;
      to_cnt      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      sns_start   <= '0;
      err_timeout <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      sns_start   <= '0;
      err_timeout <= 1'b0;
      rx_drop     <= uart.rx_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (uart.rx_valid && hit) begin
            ch        <= hit_ch;
            sns_start <= N_CH'(1) << hit_ch;
            state     <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A result arriving on the expiry cycle still wins over the timeout.
          if (sel_valid) begin
            state <= SEND;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            err_timeout <= 1'b1;
            tx_data_q   <= ERR_BYTE;
            tx_valid_q  <= 1'b1;
            state       <= ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        SEND: begin
          if (ser_done) begin
            tx_data_q  <= TERM_BYTE;
            tx_valid_q <= 1'b1;
            state      <= TERM;
          end
        end
        ERR: begin
          if (uart.tx_ready) begin
            tx_data_q <= TERM_BYTE;
            state     <= TERM;
          end
        end
        TERM: begin
          if (uart.tx_ready) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sensor_cmd_router.sv
// Directed bench: default-parameter router (TIMEOUT_CYC=50) plus a 3-channel 20-bit variant.
module tb_sensor_cmd_router;
  import sensor_router_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_a;
  logic rst_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: defaults, short timeout ----------------
  sensor_cmd_router_if if_a ();
  logic [1:0]  a_sns_start;
  logic [31:0] a_sns_data;
  logic [1:0]  a_sns_valid;
  logic        a_busy;
  logic        a_err;
  logic        a_drop;
  router_state_e a_state;

  sensor_cmd_router #(.TIMEOUT_CYC(50)) dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .uart        (if_a),
    .sns_start   (a_sns_start),
    .sns_data    (a_sns_data),
    .sns_valid   (a_sns_valid),
    .busy        (a_busy),
    .err_timeout (a_err),
    .rx_drop     (a_drop),
    .dbg_state   (a_state)
  );

  // ---------------- DUT B: 3 channels, 20-bit results ----------------
  sensor_cmd_router_if if_b ();
  logic [2:0]  b_sns_start;
  logic [59:0] b_sns_data;
  logic [2:0]  b_sns_valid;
  logic        b_busy;
  logic        b_err;
  logic        b_drop;
  router_state_e b_state;

  sensor_cmd_router #(
    .N_CH        (3),
    .DATA_W      (20),
    .CMD_CODES   ({8'h48, 8'h44, 8'h54}),
    .TIMEOUT_CYC (50)
  ) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .uart        (if_b),
    .sns_start   (b_sns_start),
    .sns_data    (b_sns_data),
    .sns_valid   (b_sns_valid),
    .busy        (b_busy),
    .err_timeout (b_err),
    .rx_drop     (b_drop),
    .dbg_state   (b_state)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    if_a.tx_ready = v;
    if_b.tx_ready = v;
  endtask

  // Presents a command for one cycle; returns at the following falling edge.
  task automatic cmd_a(input logic [7:0] code);
    if_a.rx_data  = code;
    if_a.rx_valid = 1'b1;
    tick(1);
    if_a.rx_valid = 1'b0;
  endtask

  task automatic cmd_b(input logic [7:0] code);
    if_b.rx_data  = code;
    if_b.rx_valid = 1'b1;
    tick(1);
    if_b.rx_valid = 1'b0;
  endtask

  // Drains exp_q from the tx stream; slow=1 accepts only one cycle in three.
  // Returns at the falling edge after the last accepted byte.
  task automatic collect(input bit use_b, input bit slow, input int budget);
    int         cyc;
    bit         held;
    logic [7:0] held_data;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    cyc  = 0;
    held = 1'b0;
    held_data = '0;
    while (exp_q.size() != 0 && cyc < budget) begin
      v = use_b ? if_b.tx_valid : if_a.tx_valid;
      d = use_b ? if_b.tx_data  : if_a.tx_data;
      if (held) begin
        check("hold_valid", 64'(v), 64'd1);
        check("hold_data", 64'(d), 64'(held_data));
      end
      rdy = slow ? (cyc % 3 == 2) : 1'b1;
      set_ready(rdy);
      if (v && rdy) begin
        check("tx_byte", 64'(d), 64'(exp_q.pop_front()));
        held = 1'b0;
      end else begin
        held      = v;
        held_data = d;
      end
      cyc++;
      tick(1);
    end
    set_ready(1'b0);
    check("tx_all_bytes_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.rx_data = '0; if_a.rx_valid = 1'b0; if_a.tx_ready = 1'b0;
    if_b.rx_data = '0; if_b.rx_valid = 1'b0; if_b.tx_ready = 1'b0;
    a_sns_data = '0; a_sns_valid = '0;
    b_sns_data = '0; b_sns_valid = '0;
    tick(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick(1);

    // Reset state
    check("rst_state", 64'(a_state), 64'(IDLE));
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_tx_valid", 64'(if_a.tx_valid), 64'd0);
    check("rst_tx_data", 64'(if_a.tx_data), 64'd0);
    check("rst_sns_start", 64'(a_sns_start), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_drop", 64'(a_drop), 64'd0);

    // 1: 'T' -> ch0, result A51C, always ready
    cmd_a(8'h54);
    check("t1_sns_start", 64'(a_sns_start), 64'h1);
    check("t1_busy", 64'(a_busy), 64'd1);
    tick(1);
    check("t1_start_one_cycle", 64'(a_sns_start), 64'h0);
    check("t1_wait", 64'(a_state), 64'(WAIT));
    a_sns_data  = {16'h0000, 16'hA51C};
    a_sns_valid = 2'b01;
    tick(1);
    a_sns_valid = 2'b00;
    check("t1_tx_valid_rise", 64'(if_a.tx_valid), 64'd1);
    exp_q.push_back(8'h1C); exp_q.push_back(8'hA5); exp_q.push_back(8'h0D);
    collect(1'b0, 1'b0, 20);
    check("t1_busy_low", 64'(a_busy), 64'd0);
    check("t1_tx_valid_low", 64'(if_a.tx_valid), 64'd0);

    // 2: 'D' -> ch1, result 0123, ready one cycle in three
    cmd_a(8'h44);
    check("t2_sns_start", 64'(a_sns_start), 64'h2);
    tick(1);
    a_sns_data  = {16'h0123, 16'h0000};
    a_sns_valid = 2'b10;
    tick(1);
    a_sns_valid = 2'b00;
    exp_q.push_back(8'h23); exp_q.push_back(8'h01); exp_q.push_back(8'h0D);
    collect(1'b0, 1'b1, 30);
    check("t2_busy_low", 64'(a_busy), 64'd0);

    // 3: 'T' with no result -> timeout 50 cycles into WAIT, then 'E' + terminator
    cmd_a(8'h54);
    tick(1);
    check("t3_wait_entry", 64'(a_state), 64'(WAIT));
    tick(49);
    check("t3_no_err_early", 64'(a_err), 64'd0);
    check("t3_still_wait", 64'(a_state), 64'(WAIT));
    tick(1);
    check("t3_err_pulse", 64'(a_err), 64'd1);
    check("t3_err_state", 64'(a_state), 64'(ERR));
    tick(1);
    check("t3_err_one_cycle", 64'(a_err), 64'd0);
    check("t3_e_held", 64'(if_a.tx_data), 64'h45);
    exp_q.push_back(8'h45); exp_q.push_back(8'h0D);
    collect(1'b0, 1'b0, 20);
    check("t3_busy_low", 64'(a_busy), 64'd0);

    // 4: unknown 'X' ignored; 'T' during a 'D' WAIT dropped once
    cmd_a(8'h58);
    check("t4_x_no_start", 64'(a_sns_start), 64'h0);
    check("t4_x_not_busy", 64'(a_busy), 64'd0);
    check("t4_x_no_drop", 64'(a_drop), 64'd0);
    tick(3);
    check("t4_x_no_tx", 64'(if_a.tx_valid), 64'd0);
    cmd_a(8'h44);
    check("t4_d_start", 64'(a_sns_start), 64'h2);
    tick(1);
    cmd_a(8'h54);
    check("t4_drop_pulse", 64'(a_drop), 64'd1);
    check("t4_no_restart", 64'(a_sns_start), 64'h0);
    check("t4_still_wait", 64'(a_state), 64'(WAIT));
    tick(1);
    check("t4_drop_one_cycle", 64'(a_drop), 64'd0);
    a_sns_data  = {16'hBEEF, 16'h0000};
    a_sns_valid = 2'b10;
    tick(1);
    a_sns_valid = 2'b00;
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE); exp_q.push_back(8'h0D);
    collect(1'b0, 1'b0, 20);

    // 5: ch0 strobe ignored during ch1 WAIT; ch1 result on the exact expiry cycle wins
    cmd_a(8'h44);
    tick(1);
    a_sns_data  = {16'h0000, 16'h7777};
    a_sns_valid = 2'b01;
    tick(1);
    a_sns_valid = 2'b00;
    check("t5_ch0_ignored", 64'(a_state), 64'(WAIT));
    check("t5_no_tx", 64'(if_a.tx_valid), 64'd0);
    tick(48);
    a_sns_data  = {16'h5AC3, 16'h0000};
    a_sns_valid = 2'b10;
    tick(1);
    a_sns_valid = 2'b00;
    check("t5_no_err", 64'(a_err), 64'd0);
    check("t5_send", 64'(a_state), 64'(SEND));
    exp_q.push_back(8'hC3); exp_q.push_back(8'h5A); exp_q.push_back(8'h0D);
    collect(1'b0, 1'b0, 20);

    // 6: 3-ch/20-bit variant, reset mid-SEND then a clean transfer
    cmd_b(8'h48);
    check("t6_sns_start", 64'(b_sns_start), 64'h4);
    tick(1);
    b_sns_data  = {20'hABCDE, 20'h00000, 20'h00000};
    b_sns_valid = 3'b100;
    tick(1);
    b_sns_valid = 3'b000;
    check("t6_byte0", 64'(if_b.tx_data), 64'hDE);
    set_ready(1'b1);
    tick(1);
    set_ready(1'b0);
    check("t6_byte1", 64'(if_b.tx_data), 64'hBC);
    rst_b = 1'b1;
    #1;
    check("t6_rst_tx_valid", 64'(if_b.tx_valid), 64'd0);
    check("t6_rst_tx_data", 64'(if_b.tx_data), 64'd0);
    check("t6_rst_busy", 64'(b_busy), 64'd0);
    check("t6_rst_state", 64'(b_state), 64'(IDLE));
    tick(1);
    rst_b = 1'b0;
    tick(1);
    cmd_b(8'h48);
    tick(1);
    b_sns_data  = {20'h12345, 20'h00000, 20'h00000};
    b_sns_valid = 3'b100;
    tick(1);
    b_sns_valid = 3'b000;
    exp_q.push_back(8'h45); exp_q.push_back(8'h23); exp_q.push_back(8'h01);
    exp_q.push_back(8'h0D);
    collect(1'b1, 1'b0, 20);
    check("t6_busy_low", 64'(b_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
